// File: rtl/des_pkg.sv
// des_pkg: DES tables (IP, FP, E, P, PC-1, PC-2, S-boxes, rotation amounts)
// and the bit-permutation helpers shared by the decrypt core and its key schedule.
package des_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } des_state_e;

  // All tables use DES numbering: entry value 1 names the MSB of the source word.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Decryption walks the schedule backwards, so round 0 reuses C0/D0 unrotated.
  localparam int ROT_DEC_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int ROT_ENC_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box row is indexed by {b1,b6}, column by b2..b5.
  localparam int SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
       0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
       3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
       1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
       3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
       4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
       6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
       1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
       2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[32-E_T[i]];
    return o;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
    return o;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
    return o;
  endfunction

  function automatic logic [3:0] sbox_f(input int n, input logic [5:0] b);
    return 4'(SBOX_T[n][{b[5], b[0], b[4:1]}]);
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    logic [27:0] o;
    case (n)
      1:       o = {x[0], x[27:1]};
      2:       o = {x[1:0], x[27:2]};
      default: o = x;
    endcase
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [27:0] o;
    case (n)
      1:       o = {x[26:0], x[27]};
      2:       o = {x[25:0], x[27:26]};
      default: o = x;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/des_subkey_gen_rev.sv
// des_subkey_gen_rev: holds C/D, rotates them ahead of each round and applies PC-2.
// With DES_ENCRYPT_MODE_EN the encrypt input selects the forward (left-rotate) schedule.
module des_subkey_gen_rev
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        advance,
  input  logic [3:0]  round,
`ifdef DES_ENCRYPT_MODE_EN
  input  logic        encrypt,
`endif
  output logic [47:0] subkey
);

  logic [55:0] cd_q, cd_d, cd_rot;

  // The rotation for the current round is applied combinationally so the subkey
  // is ready in the same cycle; the rotated value is kept for the next round.
  always_comb begin
`ifdef DES_ENCRYPT_MODE_EN
    if (encrypt) cd_rot = {rotl28(cd_q[55:28], ROT_ENC_T[round]), rotl28(cd_q[27:0], ROT_ENC_T[round])};
    else         cd_rot = {rotr28(cd_q[55:28], ROT_DEC_T[round]), rotr28(cd_q[27:0], ROT_DEC_T[round])};
`else
    cd_rot = {rotr28(cd_q[55:28], ROT_DEC_T[round]), rotr28(cd_q[27:0], ROT_DEC_T[round])};
`endif
  end

  always_comb begin
    cd_d = cd_q;
    if (load)         cd_d = pc1_f(key);
    else if (advance) cd_d = cd_rot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cd_q <= '0;
    else        cd_q <= cd_d;
  end

  assign subkey = pc2_f(cd_rot);

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES, one Feistel round per cycle, valid/ready in and out.
// Optional DES_ENCRYPT_MODE_EN adds an encrypt input sampled with each block.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] key,
`ifdef DES_ENCRYPT_MODE_EN
  input  logic        encrypt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy,
  output des_state_e  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until that edge, ready never depends on valid.
  des_state_e  state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [63:0] pt_q, pt_d;
  logic        ov_q, ov_d;
  logic        load, advance;
  logic [63:0] ip_ct;
  logic [47:0] subkey, ex;
  logic [31:0] sb, f_out;

`ifdef DES_ENCRYPT_MODE_EN
  logic enc_q, enc_d;
`endif

  des_subkey_gen_rev u_keygen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .key     (key),
    .advance (advance),
    .round   (round_q[3:0]),
`ifdef DES_ENCRYPT_MODE_EN
    .encrypt (enc_q),
`endif
    .subkey  (subkey)
  );

  assign ip_ct = ip_f(ciphertext);

  always_comb begin
    ex = e_f(r_q) ^ subkey;
    sb = '0;
    for (int n = 0; n < 8; n++) sb[31-4*n -: 4] = sbox_f(n, ex[47-6*n -: 6]);
    f_out = p_f(sb);
  end

  // round_q runs 0..15 for the Feistel rounds; the value 16 is the cycle that
  // applies the final swap and FP into the output register.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    l_d     = l_q;
    r_d     = r_q;
    pt_d    = pt_q;
    ov_d    = ov_q;
    load    = 1'b0;
    advance = 1'b0;
`ifdef DES_ENCRYPT_MODE_EN
    enc_d   = enc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          l_d     = ip_ct[63:32];
          r_d     = ip_ct[31:0];
          round_d = '0;
          load    = 1'b1;
`ifdef DES_ENCRYPT_MODE_EN
          enc_d   = encrypt;
`endif
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (round_q == 5'(ROUNDS)) begin
          pt_d    = fp_f({r_q, l_q});
          ov_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          l_d     = r_q;
          r_d     = l_q ^ f_out;
          round_d = round_q + 5'd1;
          advance = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      l_q     <= '0;
      r_q     <= '0;
      pt_q    <= '0;
      ov_q    <= 1'b0;
`ifdef DES_ENCRYPT_MODE_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      l_q     <= l_d;
      r_q     <= r_d;
      pt_q    <= pt_d;
      ov_q    <= ov_d;
`ifdef DES_ENCRYPT_MODE_EN
      enc_q   <= enc_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign plaintext = pt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: known-answer table, corner-case sequences and randomized
// blocks checked against a bit-level DES reference model.
module tb_des_decrypt_core;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] key = '0;
  logic [63:0] ciphertext = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] plaintext;
  des_state_e  state_dbg;
`ifdef DES_ENCRYPT_MODE_EN
  logic        encrypt = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  des_decrypt_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
`ifdef DES_ENCRYPT_MODE_EN
    .encrypt    (encrypt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] pick(input logic [63:0] x, input int win, input int wout, input int which);
    logic [63:0] o;
    int src;
    o = '0;
    for (int i = 0; i < wout; i++) begin
      case (which)
        0:       src = IP_T[i];
        1:       src = FP_T[i];
        2:       src = E_T[i];
        3:       src = P_T[i];
        4:       src = PC1_T[i];
        default: src = PC2_T[i];
      endcase
      o[wout-1-i] = x[win-src];
    end
    return o;
  endfunction

  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s;
    int b, row, col;
    t = pick({32'h0, r}, 32, 48, 2);
    x = t[47:0] ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b   = int'((x >> (42 - 6*j)) & 48'h3F);
      row = (b / 32) * 2 + (b % 2);
      col = (b / 2) % 16;
      s   = (s << 4) | 32'(SBOX_T[j][row*16 + col]);
    end
    t = pick({32'h0, s}, 32, 32, 3);
    return t[31:0];
  endfunction

  // Forward key schedule K1..K16 with left shifts; decryption just reads it backwards.
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] k, input bit dec);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, tmp;
    int sh [16];
    sh = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    t = pick(k, 64, 56, 4);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < sh[i]; s++) begin
        c = ((c << 1) | (c >> 27));
        d = ((d << 1) | (d >> 27));
      end
      t = pick({8'h0, c, d}, 56, 48, 5);
      ks[i] = t[47:0];
    end
    t = pick(blk, 64, 64, 0);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      tmp = r;
      r   = l ^ model_f(r, dec ? ks[15-i] : ks[i]);
      l   = tmp;
    end
    return pick({r, l}, 64, 64, 1);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_accept(input logic [63:0] k, input logic [63:0] c, input bit enc, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
    key        = k;
    ciphertext = c;
    in_valid   = 1'b1;
`ifdef DES_ENCRYPT_MODE_EN
    encrypt    = enc;
`else
    if (enc) $display("note: encrypt request ignored in decrypt-only build");
`endif
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    key        = {$urandom, $urandom};
    ciphertext = {$urandom, $urandom};
`ifdef DES_ENCRYPT_MODE_EN
    encrypt    = ~enc;
`endif
  endtask

  task automatic wait_valid(input bit noise, input string name);
    int  lat;
    bit  ok;
    lat = 0;
    ok  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && (in_ready !== 1'b0 || busy !== 1'b1)) ok = 1'b0;
      if (noise) begin
        in_valid   = 1'($urandom);
        ciphertext = {$urandom, $urandom};
      end
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    chk({name, " latency"}, 64'(lat), 64'd17);
    chk({name, " busy/in_ready while rounds run"}, 64'(ok), 64'd1);
  endtask

  task automatic consume(input int hold, input string name);
    logic [63:0] e, held;
    bit stable;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    held   = plaintext;
    stable = 1'b1;
    chk({name, " plaintext"}, plaintext, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (plaintext !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) chk({name, " stable under backpressure"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    chk({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    chk({name, " plaintext kept"}, plaintext, e);
  endtask

  task automatic run_block(input string name, input logic [63:0] k, input logic [63:0] c,
                           input logic [63:0] e, input int hold, input bit noise, input bit enc);
    exp_q.push_back(e);
    drive_accept(k, c, enc, name);
    wait_valid(noise, name);
    consume(hold, name);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [63:0] k;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{k: 64'h133457799BBCDFF1, ct: 64'h85E813540F0AB405, pt: 64'h0123456789ABCDEF};
    vecs[1] = '{k: 64'h0E329232EA6D0D73, ct: 64'h0000000000000000, pt: 64'h8787878787878787};
    vecs[2] = '{k: 64'h0000000000000000, ct: 64'h8CA64DE9C1B123A7, pt: 64'h0000000000000000};
    vecs[3] = '{k: 64'hFFFFFFFFFFFFFFFF, ct: 64'h7359B2163E4EDC58, pt: 64'hFFFFFFFFFFFFFFFF};

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset plaintext", plaintext, 64'd0);
    chk("reset state", 64'(state_dbg), 64'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset release", 64'(in_ready), 64'd1);

    // known-answer table, back-to-back
    for (int i = 0; i < 4; i++)
      run_block($sformatf("kat%0d", i), vecs[i].k, vecs[i].ct, vecs[i].pt, 0, 1'b0, 1'b0);

    // backpressure for 10 cycles
    run_block("backpressure", vecs[0].k, vecs[0].ct, vecs[0].pt, 10, 1'b0, 1'b0);

    // garbage in_valid/ciphertext while rounds run
    run_block("input ignore", vecs[0].k, vecs[0].ct, vecs[0].pt, 0, 1'b1, 1'b0);

    // reset at round counter 7 aborts the block
    begin
      bit quiet;
      drive_accept(vecs[1].k, vecs[1].ct, 1'b0, "midreset");
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset plaintext", plaintext, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midreset in_ready after release", 64'(in_ready), 64'd1);
      quiet = 1'b1;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk);
        #1;
        if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("midreset no output", 64'(quiet), 64'd1);
      run_block("after midreset", vecs[0].k, vecs[0].ct, vecs[0].pt, 0, 1'b0, 1'b0);
    end

    // randomized blocks against the model
    for (int i = 0; i < 24; i++) begin
      logic [63:0] k, p, c, e;
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      if (i % 2 == 0) begin
        c = des_model(p, k, 1'b0);
        e = p;
      end else begin
        c = p;
        e = des_model(p, k, 1'b1);
      end
      run_block($sformatf("rand%0d", i), k, c, e, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef DES_ENCRYPT_MODE_EN
    run_block("encrypt kat", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      logic [63:0] k, x;
      bit enc;
      k   = {$urandom, $urandom};
      x   = {$urandom, $urandom};
      enc = 1'($urandom_range(0, 1));
      run_block($sformatf("mode%0d", i), k, x, des_model(x, k, !enc), $urandom_range(0, 2), 1'b0, enc);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
